line_follow_ctrl: RTL and testbench

Parametrised line-following drive controller for the car. It turns an N-channel tracker sensor bus and the sonic obstacle flag into registered motor direction bits and per-wheel PWM. Beyond plain steering it adds lost-line recovery, obstacle hold-off with timed resume, and an optional soft-start duty ramp. It sits between the sensor front-ends (tracker, sonic) and the motor driver pins at the top level.

---
 rtl/lfc_pkg.sv | 31 +++
 rtl/lfc_pwm.sv | 46 ++++
 rtl/line_follow_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_line_follow_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/lfc_pkg.sv
// Shared types for the line-follow drive controller: FSM states, steering
// classes, wheel sides and motor direction codes.
package lfc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FOLLOW  = 3'd1,
        ST_RECOVER = 3'd2,
        ST_LOST    = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_STRAIGHT,
        CLS_TURN_L,
        CLS_SHARP_L,
        CLS_TURN_R,
        CLS_SHARP_R
    } cls_t;

    typedef enum logic {
        DIR_L = 1'b0,
        DIR_R = 1'b1
    } side_t;

    localparam logic [1:0] FWD   = 2'b10;
    localparam logic [1:0] REV   = 2'b01;
    localparam logic [1:0] COAST = 2'b00;

endpackage

// File: rtl/lfc_pwm.sv
// One wheel's PWM: duty loads only at the shared counter wrap.
// LINE_FOLLOW_RAMP_EN enables a soft-start ramp of RAMP_STEP per period.
module lfc_pwm #(
    parameter int PWM_W = 10
`ifdef LINE_FOLLOW_RAMP_EN
    , parameter int RAMP_STEP = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] cnt,
    input  logic             wrap,
    input  logic [PWM_W:0]   target,
    output logic             pwm
);

    logic [PWM_W:0] applied;

`ifdef LINE_FOLLOW_RAMP_EN
    localparam logic [PWM_W:0] STEP = (PWM_W + 1)'(RAMP_STEP);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            applied <= '0;
            pwm     <= 1'b0;
        end else begin
            if (wrap) begin
`ifdef LINE_FOLLOW_RAMP_EN
                // Ramp only upward; any reduction lands in a single period.
                if (target == '0 || applied >= target)
                    applied <= target;
                else if (target - applied <= STEP)
                    applied <= target;
                else
                    applied <= applied + STEP;
`else
                applied <= target;
`endif
            end
            // Duty of 2^PWM_W or more exceeds every count value: constant high.
            pwm <= ({1'b0, cnt} < applied);
        end
    end

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-following drive controller: steering FSM with lost-line recovery and
// obstacle hold-off. Define LINE_FOLLOW_RAMP_EN for the soft-start duty ramp.
module line_follow_ctrl
    import lfc_pkg::*;
#(
    parameter int N_SENS      = 5,
    parameter int PWM_W       = 10,
    parameter int DUTY_FULL   = 1000,
    parameter int DUTY_TURN   = 600,
    parameter int RECOVER_CYC = 50_000_000,
    parameter int RESUME_CYC  = 10_000_000
`ifdef LINE_FOLLOW_RAMP_EN
    , parameter int RAMP_STEP = 8
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [N_SENS-1:0] sens,
    input  logic              obstacle,
    output logic [1:0]        left_dir,
    output logic [1:0]        right_dir,
    output logic              left_pwm,
    output logic              right_pwm,
    output logic [2:0]        state,
    output logic              lost
);

    localparam int C      = (N_SENS - 1) / 2;
    localparam int DW     = PWM_W + 1;
    localparam int MAXCYC = (RECOVER_CYC > RESUME_CYC) ? RECOVER_CYC : RESUME_CYC;
    localparam int CW     = (MAXCYC > 2) ? $clog2(MAXCYC) : 1;
    localparam int PMAX   = 1 << PWM_W;
    localparam logic [DW-1:0] FULL_D = DW'((DUTY_FULL >= PMAX) ? PMAX : DUTY_FULL);
    localparam logic [DW-1:0] TURN_D = DW'((DUTY_TURN >= PMAX) ? PMAX : DUTY_TURN);

    logic [N_SENS-1:0] s_meta, s;
    cls_t              cls;
    int                lc, rc;
    logic [1:0]        f_ldir, f_rdir;
    logic [DW-1:0]     f_lduty, f_rduty;
    state_t            state_q;
    side_t             last_dir;
    logic [CW-1:0]     tmr;
    logic [DW-1:0]     l_tgt, r_tgt;
    logic [PWM_W-1:0]  cnt;
    logic              wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta <= '0;
            s      <= '0;
        end else begin
            s_meta <= sens;
            s      <= s_meta;
        end
    end

    always_comb begin
        lc  = 0;
        rc  = 0;
        cls = CLS_STRAIGHT;
        for (int i = 0; i < C; i++) begin
            rc = rc + int'(s[i]);
            lc = lc + int'(s[C+1+i]);
        end
        if (s == '0)
            cls = CLS_NONE;
        else if (&s)
            cls = CLS_STRAIGHT;
        else if (s[C] && lc == rc)
            cls = CLS_STRAIGHT;
        else if (lc > rc)
            cls = (s[N_SENS-1] && !s[C]) ? CLS_SHARP_L : CLS_TURN_L;
        else if (rc > lc)
            cls = (s[0] && !s[C]) ? CLS_SHARP_R : CLS_TURN_R;
    end

    always_comb begin
        f_ldir  = COAST;
        f_rdir  = COAST;
        f_lduty = '0;
        f_rduty = '0;
        case (cls)
            CLS_STRAIGHT: begin f_ldir = FWD;   f_rdir = FWD;   f_lduty = FULL_D; f_rduty = FULL_D; end
            CLS_TURN_L:   begin f_ldir = COAST; f_rdir = FWD;                     f_rduty = TURN_D; end
            CLS_SHARP_L:  begin f_ldir = REV;   f_rdir = FWD;   f_lduty = TURN_D; f_rduty = TURN_D; end
            CLS_TURN_R:   begin f_ldir = FWD;   f_rdir = COAST; f_lduty = TURN_D;                   end
            CLS_SHARP_R:  begin f_ldir = FWD;   f_rdir = REV;   f_lduty = TURN_D; f_rduty = TURN_D; end
            default: ;
        endcase
    end

    // state   | meaning
    // IDLE    | not enabled, wheels coast
    // FOLLOW  | steering from the tracker class
    // RECOVER | line gone, spinning toward last_dir, search timer running
    // LOST    | search timed out, coast until enable drops
    // HALT    | obstacle hold-off, resume after RESUME_CYC clear cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            left_dir  <= COAST;
            right_dir <= COAST;
            l_tgt     <= '0;
            r_tgt     <= '0;
            lost      <= 1'b0;
            tmr       <= '0;
            last_dir  <= DIR_L;
        end else begin
            if (cls == CLS_TURN_L || cls == CLS_SHARP_L)
                last_dir <= DIR_L;
            else if (cls == CLS_TURN_R || cls == CLS_SHARP_R)
                last_dir <= DIR_R;

            if (!enable) begin
                state_q   <= ST_IDLE;
                left_dir  <= COAST;
                right_dir <= COAST;
                l_tgt     <= '0;
                r_tgt     <= '0;
                lost      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q   <= ST_FOLLOW;
                        left_dir  <= f_ldir;
                        right_dir <= f_rdir;
                        l_tgt     <= f_lduty;
                        r_tgt     <= f_rduty;
                    end
                    ST_FOLLOW, ST_RECOVER: begin
                        if (obstacle) begin
                            state_q   <= ST_HALT;
                            left_dir  <= COAST;
                            right_dir <= COAST;
                            l_tgt     <= '0;
                            r_tgt     <= '0;
                            tmr       <= '0;
                        end else if (cls != CLS_NONE) begin
                            state_q   <= ST_FOLLOW;
                            left_dir  <= f_ldir;
                            right_dir <= f_rdir;
                            l_tgt     <= f_lduty;
                            r_tgt     <= f_rduty;
                        end else if (state_q == ST_RECOVER && tmr == CW'(RECOVER_CYC - 1)) begin
                            state_q   <= ST_LOST;
                            left_dir  <= COAST;
                            right_dir <= COAST;
                            l_tgt     <= '0;
                            r_tgt     <= '0;
                            lost      <= 1'b1;
                        end else begin
                            state_q   <= ST_RECOVER;
                            tmr       <= (state_q == ST_FOLLOW) ? '0 : tmr + CW'(1);
                            left_dir  <= (last_dir == DIR_L) ? REV : FWD;
                            right_dir <= (last_dir == DIR_L) ? FWD : REV;
                            l_tgt     <= TURN_D;
                            r_tgt     <= TURN_D;
                        end
                    end
                    ST_HALT: begin
                        if (obstacle)
                            tmr <= '0;
                        else if (tmr == CW'(RESUME_CYC - 1)) begin
                            state_q   <= ST_FOLLOW;
                            left_dir  <= f_ldir;
                            right_dir <= f_rdir;
                            l_tgt     <= f_lduty;
                            r_tgt     <= f_rduty;
                        end else
                            tmr <= tmr + CW'(1);
                    end
                    ST_LOST: ;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt + PWM_W'(1);
    end

    assign wrap = &cnt;

`ifdef LINE_FOLLOW_RAMP_EN
    lfc_pwm #(.PWM_W(PWM_W), .RAMP_STEP(RAMP_STEP)) u_pwm_l (
`else
    lfc_pwm #(.PWM_W(PWM_W)) u_pwm_l (
`endif
        .clk(clk), .rst_n(rst_n), .cnt(cnt), .wrap(wrap), .target(l_tgt), .pwm(left_pwm)
    );

`ifdef LINE_FOLLOW_RAMP_EN
    lfc_pwm #(.PWM_W(PWM_W), .RAMP_STEP(RAMP_STEP)) u_pwm_r (
`else
    lfc_pwm #(.PWM_W(PWM_W)) u_pwm_r (
`endif
        .clk(clk), .rst_n(rst_n), .cnt(cnt), .wrap(wrap), .target(r_tgt), .pwm(right_pwm)
    );

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Directed bench for line_follow_ctrl: steering classes, recovery timeout,
// obstacle hold-off timing, PWM duty and reset behaviour.
module tb_line_follow_ctrl;

    localparam int N  = 5;
    localparam int PW = 4;

    logic         clk, rst_n, enable, obstacle;
    logic [N-1:0] sens;
    logic [1:0]   left_dir, right_dir;
    logic         left_pwm, right_pwm, lost;
    logic [2:0]   state;

    int total = 0;
    int bad   = 0;
    int lcnt, rcnt;

    line_follow_ctrl #(
        .N_SENS(N), .PWM_W(PW), .DUTY_FULL(12), .DUTY_TURN(6),
        .RECOVER_CYC(40), .RESUME_CYC(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sens(sens), .obstacle(obstacle),
        .left_dir(left_dir), .right_dir(right_dir), .left_pwm(left_pwm),
        .right_pwm(right_pwm), .state(state), .lost(lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic meas(output int l, output int r);
        l = 0;
        r = 0;
        repeat (16) begin
            step(1);
            l += int'(left_pwm);
            r += int'(right_pwm);
        end
    endtask

    // Apply a tracker pattern and check the drive three clocks later.
    task automatic steer(input string tag, input logic [N-1:0] pat,
                         input logic [1:0] ld, input logic [1:0] rd);
        sens = pat;
        step(3);
        chk({tag, "_l"}, 32'(left_dir), 32'(ld));
        chk({tag, "_r"}, 32'(right_dir), 32'(rd));
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; obstacle = 1'b0; sens = '0;
        #3;
        chk("rst_state", 32'(state), 0);
        chk("rst_dirs", {left_dir, right_dir}, 0);
        chk("rst_pwm", {left_pwm, right_pwm}, 0);
        chk("rst_lost", 32'(lost), 0);
        step(2);
        rst_n = 1'b1;
        meas(lcnt, rcnt);
        chk("idle_duty", 32'(lcnt + rcnt), 0);

        sens = 5'b00100;
        step(3);
        enable = 1'b1;
        step(1);
        chk("follow_state", 32'(state), 1);
        chk("follow_l", 32'(left_dir), 2);
        chk("follow_r", 32'(right_dir), 2);
        step(40);
        meas(lcnt, rcnt);
        chk("full_duty_l", 32'(lcnt), 12);
        chk("full_duty_r", 32'(rcnt), 12);

        // Two clocks after the edge the old decision must still hold.
        sens = 5'b01100;
        step(2);
        chk("lat2_l", 32'(left_dir), 2);
        step(1);
        chk("turnl_l", 32'(left_dir), 0);
        chk("turnl_r", 32'(right_dir), 2);
        step(40);
        meas(lcnt, rcnt);
        chk("turn_duty_l", 32'(lcnt), 0);
        chk("turn_duty_r", 32'(rcnt), 6);

        steer("sharpl", 5'b10000, 2'b01, 2'b10);
        steer("turnl_c", 5'b11100, 2'b00, 2'b10);
        steer("str_eq", 5'b01110, 2'b10, 2'b10);
        steer("str_odd", 5'b10001, 2'b10, 2'b10);
        steer("str_all", 5'b11111, 2'b10, 2'b10);
        steer("turnr", 5'b00110, 2'b10, 2'b00);
        steer("sharpr", 5'b00001, 2'b10, 2'b01);

        sens = 5'b00000;
        step(3);
        chk("recover_state", 32'(state), 2);
        chk("recover_dirs", {left_dir, right_dir}, 4'b1001);
        step(39);
        chk("recover_39", 32'(state), 2);
        chk("recover_lost0", 32'(lost), 0);
        step(1);
        chk("lost_state", 32'(state), 3);
        chk("lost_flag", 32'(lost), 1);
        chk("lost_dirs", {left_dir, right_dir}, 0);
        enable = 1'b0;
        step(1);
        chk("idle_state", 32'(state), 0);
        chk("idle_lost", 32'(lost), 0);

        sens = 5'b00100;
        step(3);
        enable = 1'b1;
        step(1);
        chk("refollow", 32'(state), 1);
        obstacle = 1'b1;
        step(1);
        chk("halt_state", 32'(state), 4);
        chk("halt_dirs", {left_dir, right_dir}, 0);
        obstacle = 1'b0;
        step(5);
        chk("halt_5", 32'(state), 4);
        obstacle = 1'b1;
        step(1);
        obstacle = 1'b0;
        step(9);
        chk("halt_9", 32'(state), 4);
        step(1);
        chk("resume_state", 32'(state), 1);
        chk("resume_dirs", {left_dir, right_dir}, 4'b1010);

        // Obstacle must win over line loss; recovery re-acquires the line.
        sens = 5'b00000;
        step(3);
        chk("recover2", 32'(state), 2);
        chk("recover2_dirs", {left_dir, right_dir}, 4'b1001);
        obstacle = 1'b1;
        step(1);
        chk("recover_halt", 32'(state), 4);
        obstacle = 1'b0;
        step(10);
        chk("halt_to_follow", 32'(state), 1);
        step(1);
        chk("follow_to_recover", 32'(state), 2);
        steer("reacq", 5'b01000, 2'b00, 2'b10);
        chk("reacq_state", 32'(state), 1);

        rst_n = 1'b0;
        #2;
        chk("midrst_state", 32'(state), 0);
        chk("midrst_dirs", {left_dir, right_dir}, 0);
        chk("midrst_pwm", {left_pwm, right_pwm}, 0);
        step(1);
        rst_n = 1'b1;
        chk("post_rst_idle", 32'(state), 0);
        step(1);
        chk("post_rst_follow", 32'(state), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
